// File: rtl/i2c_arbiter_pkg.sv
`default_nettype none
// ==== i2c_arbiter_pkg : FSM state encoding, default timeout, ring-index helper (rev 1.0) ====

package i2c_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] c_TIMEOUT_DEFAULT = 16'd50000;
  localparam int          c_ADDR_W          = 7;
  localparam int          c_DATA_W          = 8;

  // base + inc on a ring of n entries; callers keep base < n and inc <= n
  function automatic int wrap_add(input int base, input int inc, input int n);
    int s;
    s = base + inc;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_arbiter_if.sv
`default_nettype none
// ==== i2c_arbiter_if : transaction fields and handshake toward the I2C controller (rev 1.0) ====

interface i2c_arbiter_if;
  import i2c_arbiter_pkg::*;

  logic [c_ADDR_W-1:0] ctl_addr;
  logic [c_DATA_W-1:0] ctl_wdata;
  logic                ctl_rw;
  logic                ctl_enable;
  logic                ctl_ready;
  logic [c_DATA_W-1:0] ctl_rdata;

  modport master (
    output ctl_addr, ctl_wdata, ctl_rw, ctl_enable,
    input  ctl_ready, ctl_rdata
  );

  modport slave (
    input  ctl_addr, ctl_wdata, ctl_rw, ctl_enable,
    output ctl_ready, ctl_rdata
  );

endinterface

`default_nettype wire

// File: rtl/i2c_arbiter_rr_picker.sv
`default_nettype none
// ==== rr_picker : round-robin winner search starting one past ptr (rev 1.0) ====

module rr_picker
  import i2c_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   index,
  output logic               valid
);

  logic [IDX_W-1:0] w_cand;

  // k = NUM_REQ revisits ptr itself, so the last owner is only chosen when nobody else asks
  always_comb begin
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'(wrap_add(int'(ptr), k, NUM_REQ));
      if (!valid && req[w_cand]) begin
        valid          = 1'b1;
        index          = w_cand;
        winner[w_cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_arbiter.sv
`default_nettype none
// ==== i2c_arbiter : round-robin arbitration of NUM_REQ requesters onto one I2C controller (rev 1.0) ====

module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter logic [15:0] TIMEOUT = c_TIMEOUT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [c_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [c_DATA_W*NUM_REQ-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]          req_rw,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic [NUM_REQ-1:0]          err,
  output logic [c_DATA_W-1:0]         rdata,
  output logic                        busy,
  i2c_arbiter_if.master               ctl
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  state_t              r_state, w_state_nxt;
  logic [c_IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [c_IDX_W-1:0]  r_owner, w_owner_nxt;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]  r_done, w_done_nxt;
  logic [NUM_REQ-1:0]  r_err, w_err_nxt;
  logic [c_DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic [c_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [c_DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic                r_rw, w_rw_nxt;
  logic [15:0]         r_cnt, w_cnt_nxt;
  logic                w_timeout;
  logic                w_abort;

  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [c_IDX_W-1:0]  w_pick_idx;
  logic                w_pick_valid;

  logic [c_ADDR_W-1:0] w_addr_arr  [NUM_REQ];
  logic [c_DATA_W-1:0] w_wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[c_ADDR_W*gi +: c_ADDR_W];
    assign w_wdata_arr[gi] = req_wdata[c_DATA_W*gi +: c_DATA_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr_picker (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_pick_onehot),
    .index  (w_pick_idx),
    .valid  (w_pick_valid)
  );

  assign w_timeout = (r_cnt == (TIMEOUT - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= c_IDX_W'(NUM_REQ - 1);
      r_owner <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rw    <= w_rw_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_rdata_nxt = r_rdata;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rw_nxt    = r_rw;
    w_abort     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid && ctl.ctl_ready) begin
          w_state_nxt = ST_ISSUE;
          w_owner_nxt = w_pick_idx;
          w_grant_nxt = w_pick_onehot;
          w_addr_nxt  = w_addr_arr[w_pick_idx];
          w_wdata_nxt = w_wdata_arr[w_pick_idx];
          w_rw_nxt    = req_rw[w_pick_idx];
        end
      end
      ST_ISSUE: begin
        // ready going low is the controller's acknowledgement of the start request
        if (!ctl.ctl_ready) begin
          w_state_nxt = ST_WAIT;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      ST_WAIT: begin
        if (ctl.ctl_ready) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = r_grant;
          if (r_rw) begin
            w_rdata_nxt = ctl.ctl_rdata;
          end
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_ptr_nxt   = r_owner;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_err_nxt   = r_grant;
      w_grant_nxt = '0;
      w_ptr_nxt   = r_owner;
    end

    w_cnt_nxt = ((w_state_nxt != r_state) || (r_state == ST_IDLE)) ? 16'd0 : (r_cnt + 16'd1);
  end

  assign grant          = r_grant;
  assign done           = r_done;
  assign err            = r_err;
  assign rdata          = r_rdata;
  assign busy           = (r_state != ST_IDLE);
  assign ctl.ctl_enable = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign ctl.ctl_addr   = r_addr;
  assign ctl.ctl_wdata  = r_wdata;
  assign ctl.ctl_rw     = r_rw;

endmodule

`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
// ==== tb_i2c_arbiter : directed and randomized checks of i2c_arbiter against a round-robin model (rev 1.0) ====

module tb_i2c_arbiter;

  localparam int          NREQ = 4;
  localparam logic [15:0] TO   = 16'd100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [27:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_rw;
  logic [3:0]   grant, done, err;
  logic [7:0]   rdata;
  logic         busy;

  i2c_arbiter_if bus ();

  i2c_arbiter #(
    .NUM_REQ (NREQ),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rw    (req_rw),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .ctl       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] addr_a  [4];
  logic [7:0] wdata_a [4];
  logic       rw_a    [4];
  int         last_owner;
  logic [7:0] rdata_exp;

  // controller model knobs
  int         m_drop, m_busy, m_cnt, m_phase, m_rise_cyc;
  bit         m_nodrop, m_force_low;
  logic [7:0] m_rdata;

  initial begin
    m_drop = 1; m_busy = 4; m_cnt = 0; m_phase = 0; m_rise_cyc = 0;
    m_nodrop = 1'b0; m_force_low = 1'b0; m_rdata = 8'h00;
    bus.ctl_ready = 1'b1;
    bus.ctl_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_phase = 0; m_cnt = 0; bus.ctl_ready = 1'b1;
      end else if (m_force_low) begin
        bus.ctl_ready = 1'b0;
      end else begin
        case (m_phase)
          0: begin
            bus.ctl_ready = 1'b1;
            if (bus.ctl_enable && !m_nodrop) begin
              if (m_cnt >= m_drop) begin
                bus.ctl_ready = 1'b0; m_phase = 1; m_cnt = 0;
              end else begin
                m_cnt++;
              end
            end else if (!bus.ctl_enable) begin
              m_cnt = 0;
            end
          end
          1: begin
            m_cnt++;
            if (m_cnt >= m_busy) begin
              bus.ctl_ready = 1'b1; bus.ctl_rdata = m_rdata;
              m_rise_cyc = cyc; m_phase = 2;
            end
          end
          default: begin
            if (!bus.ctl_enable) begin
              m_phase = 0; m_cnt = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_fields();
    for (int i = 0; i < 4; i++) begin
      req_addr[7*i +: 7]  = addr_a[i];
      req_wdata[8*i +: 8] = wdata_a[i];
      req_rw[i]           = rw_a[i];
    end
  endtask

  task automatic scramble_fields();
    for (int i = 0; i < 4; i++) begin
      addr_a[i]  = 7'($urandom);
      wdata_a[i] = 8'($urandom);
      rw_a[i]    = 1'($urandom);
    end
    pack_fields();
  endtask

  // next owner: first requester after the previous owner, going round the ring
  function automatic int rr_expect(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (m[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_txn(input int drop_dly, input int busy_len, input logic [7:0] rd,
                        input bit drop_req, input bit scramble, input int exp_lat);
    int         exp_i, t;
    logic [3:0] oh;
    logic [6:0] ea;
    logic [7:0] ew;
    logic       er;
    m_drop = drop_dly; m_busy = busy_len; m_rdata = rd;
    exp_i = rr_expect(req, last_owner);
    oh = '0; oh[exp_i] = 1'b1;
    ea = addr_a[exp_i]; ew = wdata_a[exp_i]; er = rw_a[exp_i];
    t = 0;
    while (grant === 4'b0 && t < 50) begin @(negedge clk); t++; end
    check("grant", grant, oh);
    if (exp_lat >= 0) check("grant_lat", t, exp_lat);
    check("ctl_addr", bus.ctl_addr, ea);
    check("ctl_wdata", bus.ctl_wdata, ew);
    check("ctl_rw", bus.ctl_rw, er);
    check("busy", busy, 1);
    if (scramble) scramble_fields();
    t = 0;
    while (bus.ctl_ready !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    check("enable_in_wait", bus.ctl_enable, 1);
    if (drop_req) req[exp_i] = 1'b0;
    t = 0;
    while (done === 4'b0 && err === 4'b0 && t < 100) begin @(negedge clk); t++; end
    check("done", done, oh);
    check("err_none", err, 0);
    check("done_lat", cyc - m_rise_cyc, 1);
    check("enable_drop", bus.ctl_enable, 0);
    check("addr_hold", bus.ctl_addr, ea);
    check("wdata_hold", bus.ctl_wdata, ew);
    check("rw_hold", bus.ctl_rw, er);
    if (er) rdata_exp = rd;
    check("rdata", rdata, rdata_exp);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("grant_clear", grant, 0);
    check("rdata_hold", rdata, rdata_exp);
    last_owner = exp_i;
  endtask

  initial begin
    int         t, gcyc, exp_i;
    logic [3:0] oh;

    rst_n = 1'b0; req = 4'b0; req_addr = '0; req_wdata = '0; req_rw = '0;
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 7'h10 + 7'(i); wdata_a[i] = 8'h80 + 8'(i); rw_a[i] = 1'b0;
    end
    pack_fields();
    last_owner = NREQ - 1;
    rdata_exp  = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_enable", bus.ctl_enable, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", bus.ctl_addr, 0);
    rst_n = 1'b1;

    // idle with no requests
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_enable", bus.ctl_enable, 0);
    end

    // controller not ready: requests must wait
    m_force_low = 1'b1;
    @(negedge clk);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("notready_grant", grant, 0);
    end
    m_force_low = 1'b0;

    // all requesting: 0,1,2,3,0
    do_txn(1, 4, 8'h00, 1'b0, 1'b0, -1);
    for (int i = 0; i < 4; i++) do_txn(2, 3, 8'h00, 1'b0, 1'b0, 1);

    // sole write requester, re-granted back to back
    req = 4'b0001; addr_a[0] = 7'h50; wdata_a[0] = 8'hA5; rw_a[0] = 1'b0; pack_fields();
    do_txn(3, 20, 8'h00, 1'b0, 1'b0, 1);

    // read from requester 2
    req = 4'b0100; addr_a[2] = 7'h1E; rw_a[2] = 1'b1; pack_fields();
    do_txn(2, 6, 8'h3C, 1'b0, 1'b0, 1);
    rw_a[2] = 1'b0; pack_fields();

    // owner withdraws during WAIT; next grant must move past it
    req = 4'b1111;
    do_txn(1, 5, 8'h00, 1'b1, 1'b0, 1);
    do_txn(1, 5, 8'h00, 1'b0, 1'b0, 1);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      req = 4'($urandom_range(1, 15));
      scramble_fields();
      do_txn(int'($urandom_range(0, 4)), int'($urandom_range(1, 12)), 8'($urandom),
             ($urandom_range(0, 3) == 0), 1'b1, 1);
    end

    // controller never acknowledges: abort after TO cycles in ISSUE
    m_nodrop = 1'b1;
    req = 4'b0010;
    exp_i = rr_expect(req, last_owner);
    oh = '0; oh[exp_i] = 1'b1;
    t = 0;
    while (grant === 4'b0 && t < 50) begin @(negedge clk); t++; end
    check("to_grant", grant, oh);
    gcyc = cyc;
    t = 0;
    while (err === 4'b0 && done === 4'b0 && t < 300) begin @(negedge clk); t++; end
    req = 4'b0000;
    check("to_err", err, oh);
    check("to_done", done, 0);
    check("to_lat", cyc - gcyc, TO);
    check("to_rdata", rdata, rdata_exp);
    @(negedge clk);
    check("to_err_pulse", err, 0);
    check("to_enable", bus.ctl_enable, 0);
    check("to_busy", busy, 0);
    last_owner = exp_i;
    m_nodrop = 1'b0;

    // reset during WAIT
    req = 4'b1111; m_drop = 1; m_busy = 15;
    t = 0;
    while (bus.ctl_ready !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_grant", grant, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_rdata", rdata, 0);
    check("arst_busy", busy, 0);
    check("arst_enable", bus.ctl_enable, 0);
    check("arst_addr", bus.ctl_addr, 0);
    check("arst_wdata", bus.ctl_wdata, 0);
    check("arst_rw", bus.ctl_rw, 0);
    repeat (2) @(negedge clk);
    check("rst_no_done", done, 0);
    rst_n = 1'b1;
    last_owner = NREQ - 1;
    rdata_exp = 8'h00;
    do_txn(1, 4, 8'h00, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, meaning the clk cycles allowed per handshake phase before abort.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester transaction request, level.
REQ-006 SHALL have port req_addr  input  7*NUM_REQ  per-requester 7-bit slave address, requester i at bits [7i+6:7i].
REQ-007 SHALL have port req_wdata  input  8*NUM_REQ  per-requester write byte.
REQ-008 SHALL have port req_rw  input  NUM_REQ  per-requester direction, 1=read.
REQ-009 SHALL have port grant  output  NUM_REQ  one-hot owner of the current transaction.
REQ-010 SHALL have port done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-011 SHALL have port err  output  NUM_REQ  one-cycle timeout pulse to the owner.
REQ-012 SHALL have port rdata  output  8  read byte, valid in the done cycle and held until the next done.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port ctl_addr, ctl_wdata, ctl_rw  outputs  7/8/1  registered transaction fields toward the I2C controller.
REQ-015 SHALL have port ctl_enable  output  1  start request to the controller.
REQ-016 SHALL have ports ctl_ready (input, 1, controller idle) and ctl_rdata (input, 8, controller read byte).

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-018 In IDLE with any req high and ctl_ready high, SHALL pick a winner round-robin starting at rr_ptr+1 mod NUM_REQ, latch its addr/wdata/rw into ctl_*, set grant, and go to ISSUE.
REQ-019 In ISSUE, SHALL hold ctl_enable high until ctl_ready samples low, then go to WAIT; ctl_enable SHALL stay high through WAIT and drop on entry to DONE.
REQ-020 In WAIT, SHALL on ctl_ready high capture ctl_rdata into rdata (reads only) and go to DONE.
REQ-021 In DONE, SHALL pulse done[owner] for exactly one cycle, clear grant, set rr_ptr to the owner, and return to IDLE.
REQ-022 The latency from IDLE with req high to the grant output SHALL be 1 cycle; done SHALL follow the ctl_ready rise by 1 cycle.
REQ-023 A 16-bit phase counter SHALL clear on every state change; reaching TIMEOUT in ISSUE or WAIT SHALL drop ctl_enable, pulse err[owner] instead of done, leave rdata unchanged, update rr_ptr, and return to IDLE.
REQ-024 The ctl_addr, ctl_wdata, and ctl_rw fields SHALL remain stable from ISSUE until exit from WAIT; changes to req_* after the grant SHALL be ignored.
REQ-025 A requester dropping req mid-transaction SHALL NOT abort it; done is still pulsed.
REQ-026 With all req low, the block SHALL stay in IDLE with ctl_enable low.
REQ-027 When the owner keeps req high after done and another requester is waiting, the other requester SHALL win next (fairness); a sole requester SHALL be re-granted back-to-back.
REQ-028 In IDLE, if ctl_ready is low, no grant SHALL issue.
REQ-029 The rr_ptr SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-030 On rst_n low, outputs SHALL asynchronously clear: grant=0, done=0, err=0, rdata=0, busy=0, ctl_enable=0, ctl_addr=0, ctl_wdata=0, ctl_rw=0; state=IDLE; rr_ptr=NUM_REQ-1 (so requester 0 is first); counter=0.
REQ-031 Reset mid-transaction SHALL abandon the transaction without a done or err pulse.

Structure
REQ-032 A shared package SHALL hold the FSM state encodings and the default TIMEOUT constant.
REQ-033 The round-robin picker SHALL be one sub-module, rr_picker (req, ptr -> one-hot winner, index, valid).

Verification
REQ-034 With req=4'b0001, addr=7'h50, wdata=8'hA5, rw=0, and a controller model that drops ready after 3 cycles and raises it after 20, the bench SHALL see grant=0001, ctl_addr=50, ctl_wdata=A5, and done[0] exactly 1 cycle after the ready rise.
REQ-035 With req=4'b1111 held, the bench SHALL see grants in the order 0,1,2,3,0 and one done per grant.
REQ-036 With req[2] read, addr=7'h1E, and the model returning 8'h3C, the bench SHALL see rdata=8'h3C in the done[2] cycle, held afterwards.
REQ-037 With ctl_ready never dropping and TIMEOUT=100, the bench SHALL see err[owner] after 100 cycles in ISSUE, no done, and ctl_enable low afterwards.
REQ-038 With rst_n pulsed low during WAIT, the bench SHALL see all outputs 0 immediately and the next grant to requester 0.
REQ-039 With the owner dropping req in WAIT, the bench SHALL still see done pulsed and rr_ptr advanced.
